// File: rtl/mem_bist_if.sv
// ============================================================================
// Module      : mem_bist_if
// Description : Write/read request bus between the memory BIST controller and
//               one RAM port. The master (BIST) issues one-cycle write and
//               read strobes; the slave (RAM port) returns read data in
//               request order, qualified by rd_data_valid.
// Ports       : wr_rdy        slave->master  RAM ready for a write
//               rd_rdy        slave->master  RAM ready for a read request
//               rd_data_valid slave->master  rd_data holds a returned word
//               rd_data       slave->master  read return data
//               wr_en         master->slave  one-cycle write strobe
//               wr_addr       master->slave  write address
//               wr_data       master->slave  write data
//               rd_en         master->slave  one-cycle read request strobe
//               rd_addr       master->slave  read address
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_bist_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32
);
  logic                  wr_rdy;
  logic                  rd_rdy;
  logic                  rd_data_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;

  modport master (
    input  wr_rdy, rd_rdy, rd_data_valid, rd_data,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr
  );

  modport slave (
    output wr_rdy, rd_rdy, rd_data_valid, rd_data,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr
  );
endinterface

`default_nettype wire

// File: rtl/mem_bist_ctrl.sv
// ============================================================================
// Module      : mem_bist_ctrl
// Description : Memory self-test traffic generator and checker. A rising edge
//               on start writes NUM_WORDS pattern words from BASE_ADDR, reads
//               them back in order and compares the low CMP_WIDTH bits of each
//               return against the same pattern. Reports pass/fail, a
//               saturating mismatch count, the first failing address and a
//               readback stall timeout.
// Ports       : clk            system clock
//               reset          asynchronous assert, active-low reset
//               start          rising edge starts a run (only in IDLE/DONE)
//               bus            mem_bist_if master modport (RAM port traffic)
//               busy           run in progress
//               done           run finished, held until next start
//               pass           done with no mismatch and no timeout
//               fail           any mismatch or timeout, sticky until start
//               timeout        readback stalled TIMEOUT cycles
//               err_cnt        mismatches this run, saturating
//               first_err_addr address of first mismatch (0 if none)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bist_ctrl #(
  parameter int                    ADDR_WIDTH = 24,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    CMP_WIDTH  = 24,
  parameter int                    NUM_WORDS  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [CMP_WIDTH-1:0]  TST_PATT   = {CMP_WIDTH{1'b1}},
  parameter int                    PATT_MODE  = 0,
  parameter int                    TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  mem_bist_if.master            bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  // Index counters must be able to hold NUM_WORDS itself (the "finished" value)
  localparam int IDX_W = $clog2(NUM_WORDS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] NUM_IDX   = IDX_W'(NUM_WORDS);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]       state;
  logic             start_d;
  logic [IDX_W-1:0] widx;      // next word to write
  logic [IDX_W-1:0] ridx;      // next word to request
  logic [IDX_W-1:0] cidx;      // next word expected back
  logic [TMO_W-1:0] tmo_cnt;

  logic start_rise;
  logic rd_active;
  logic take_ret;
  logic mismatch;
  logic tmo_counting;
  logic tmo_hit;

  // Only the low CMP_WIDTH bits of a return are checked; the rest is don't-care
  logic unused_rd_bits;
  assign unused_rd_bits = ^bus.rd_data;

  // --------------------------------------------------------------------------
  // Expected pattern for word idx, and the address it lives at. Address sums
  // are truncated to ADDR_WIDTH so a run near the top of memory wraps to 0.
  // --------------------------------------------------------------------------
  function automatic logic [CMP_WIDTH-1:0] pattern(input logic [IDX_W-1:0] idx);
    logic [CMP_WIDTH-1:0] idx_ext;
    idx_ext = CMP_WIDTH'(idx);
    if (PATT_MODE == 1) begin
      return idx_ext ^ TST_PATT;
    end
    return TST_PATT;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + ADDR_WIDTH'(idx);
  endfunction

  assign start_rise = start & ~start_d;
  assign rd_active  = (state == ST_READ) || (state == ST_DRAIN);

  // Extra returns beyond NUM_WORDS are not compared
  assign take_ret   = rd_active && bus.rd_data_valid && (cidx != NUM_IDX);
  assign mismatch   = take_ret && (bus.rd_data[CMP_WIDTH-1:0] != pattern(cidx));

  // Stall timer runs only while something is owed to us
  assign tmo_counting = rd_active && ((cidx < ridx) || (state == ST_DRAIN));
  assign tmo_hit      = tmo_counting && !bus.rd_data_valid && (tmo_cnt == TMO_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      start_d        <= 1'b0;
      widx           <= '0;
      ridx           <= '0;
      cidx           <= '0;
      tmo_cnt        <= '0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.rd_en      <= 1'b0;
      bus.rd_addr    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      start_d <= start;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_rise) begin
            state          <= ST_WRITE;
            widx           <= '0;
            ridx           <= '0;
            cidx           <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
          end
        end

        ST_WRITE: begin
          // A strobe is always followed by an idle cycle, so each is one cycle
          if (bus.wr_en) begin
            bus.wr_en <= 1'b0;
            if (widx == NUM_IDX) begin
              state   <= ST_READ;
              tmo_cnt <= '0;
            end
          end else if (bus.wr_rdy && (widx != NUM_IDX)) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= addr_of(widx);
            bus.wr_data <= DATA_WIDTH'(pattern(widx));
            widx        <= widx + IDX_W'(1);
          end
        end

        ST_READ: begin
          if (tmo_hit) begin
            state     <= ST_DONE;
            bus.rd_en <= 1'b0;
            timeout   <= 1'b1;
            fail      <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            pass      <= 1'b0;
          end else if (bus.rd_en) begin
            bus.rd_en <= 1'b0;
            if (ridx == NUM_IDX) begin
              state <= ST_DRAIN;
            end
          end else if (bus.rd_rdy && (ridx != NUM_IDX)) begin
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= addr_of(ridx);
            ridx        <= ridx + IDX_W'(1);
          end
        end

        ST_DRAIN: begin
          if (cidx == NUM_IDX) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= ~fail;
          end else if (tmo_hit) begin
            state   <= ST_DONE;
            timeout <= 1'b1;
            fail    <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            pass    <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Readback checking overlaps READ and DRAIN; returns arrive in order
      if (take_ret) begin
        cidx <= cidx + IDX_W'(1);
        if (mismatch) begin
          fail <= 1'b1;
          if (err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
          end
          if (err_cnt == 16'd0) begin
            first_err_addr <= addr_of(cidx);
          end
        end
      end

      // Stall timer: any return restarts it
      if (rd_active) begin
        if (bus.rd_data_valid) begin
          tmo_cnt <= '0;
        end else if (tmo_counting && !tmo_hit) begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire
